// File: rtl/cen_mon_pkg.sv
// Shared definitions for the clock-enable rate monitor: FSM states,
// gap tracker widths and the nominal CEN rates produced by the core.
package cen_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2
  } mon_state_t;

  localparam int         GAP_W   = 8;
  localparam logic [7:0] GAP_SAT = 8'd255;

  // Nominal pulses per 1 ms window for the core's enable generators:
  // video 13.5 / 6.75 MHz, audio 3.375 / 1.6875 MHz, OKI 2.7 MHz.
  localparam int unsigned CEN_RATES [5] = '{13500, 6750, 3375, 1688, 2700};

  // Gap counter increment that sticks at the saturation value.
  function automatic logic [GAP_W-1:0] gap_sat_inc(input logic [GAP_W-1:0] v);
    return (v == GAP_SAT) ? GAP_SAT : v + GAP_W'(1);
  endfunction

endpackage

// File: rtl/cen_gap_tracker.sv
// Inter-pulse gap measurement with per-window min/max. The min/max outputs
// already include a gap closed in the current cycle, so the parent can
// publish them on the window's terminal cycle without an extra stage.
module cen_gap_tracker
  import cen_mon_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic             win_start,
  output logic [GAP_W-1:0] min_gap,
  output logic [GAP_W-1:0] max_gap
);

  logic [GAP_W-1:0] gap_cnt_reg;
  logic             have_prev_reg;
  logic [GAP_W-1:0] min_reg;
  logic [GAP_W-1:0] max_reg;

  logic [GAP_W-1:0] closed_gap;
  logic             gap_closed;
  logic [GAP_W-1:0] min_base;
  logic [GAP_W-1:0] max_base;

  // Fold a gap closed this cycle into the running extremes; the trackers
  // restart from 255/0 on the first cycle of each window.
  always_comb begin
    closed_gap = gap_sat_inc(gap_cnt_reg);
    gap_closed = cen && have_prev_reg;
    min_base   = win_start ? GAP_SAT : min_reg;
    max_base   = win_start ? '0 : max_reg;
    min_gap    = (gap_closed && (closed_gap < min_base)) ? closed_gap : min_base;
    max_gap    = (gap_closed && (closed_gap > max_base)) ? closed_gap : max_base;
  end

  // Gap counter runs freely across window boundaries; the first pulse after
  // a clear only arms it.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt_reg   <= '0;
      have_prev_reg <= 1'b0;
      min_reg       <= GAP_SAT;
      max_reg       <= '0;
    end else begin
      if (cen) begin
        gap_cnt_reg   <= '0;
        have_prev_reg <= 1'b1;
      end else begin
        gap_cnt_reg <= gap_sat_inc(gap_cnt_reg);
      end
      min_reg <= min_gap;
      max_reg <= max_gap;
    end
  end

endmodule

// File: rtl/cen_rate_monitor.sv
// Clock-enable rate monitor: counts CEN pulses per fixed window, reports
// min/max inter-pulse gap, and tracks lock against an expected rate.
module cen_rate_monitor
  import cen_mon_pkg::*;
#(
  parameter int WINDOW = 96000,
  parameter int EXPECT = 13500,
  parameter int TOL    = 2,
  parameter int CW     = 24
) (
  input  logic          CLK96,
  input  logic          RESET,
  input  logic          EN,
  input  logic          CEN,
  output logic [CW-1:0] COUNT,
  output logic [7:0]    MIN_GAP,
  output logic [7:0]    MAX_GAP,
  output logic          VALID,
  output logic          LOCKED,
  output logic          ERR
);

  localparam int WCW = $clog2(WINDOW);
  localparam logic [WCW-1:0] WIN_LAST = WCW'(WINDOW - 1);
  // Bounds carried one bit wider and signed so EXPECT-TOL can go negative.
  localparam logic signed [CW:0] TOL_LO = (CW+1)'(EXPECT - TOL);
  localparam logic signed [CW:0] TOL_HI = (CW+1)'(EXPECT + TOL);

  mon_state_t       state_reg;
  logic [WCW-1:0]   win_cnt_reg;
  logic [CW-1:0]    acc_reg;
  logic             run_reg;

  logic             win_start;
  logic             win_end;
  logic             trk_rst;
  logic [CW-1:0]    count_next;
  logic signed [CW:0] count_s;
  logic             in_tol;
  logic [GAP_W-1:0] trk_min;
  logic [GAP_W-1:0] trk_max;

  // Window position, saturating pulse count including this cycle's CEN,
  // and the tolerance test applied at the terminal cycle.
  always_comb begin
    win_start  = (win_cnt_reg == '0);
    win_end    = (win_cnt_reg == WIN_LAST);
    trk_rst    = RESET || (state_reg == ST_IDLE);
    count_next = (CEN && !(&acc_reg)) ? acc_reg + CW'(1) : acc_reg;
    count_s    = $signed({1'b0, count_next});
    in_tol     = (count_s >= TOL_LO) && (count_s <= TOL_HI);
  end

  cen_gap_tracker u_gap (
    .clk       (CLK96),
    .rst       (trk_rst),
    .cen       (CEN),
    .win_start (win_start),
    .min_gap   (trk_min),
    .max_gap   (trk_max)
  );

  // Control FSM with registered publish/lock outputs.
  always_ff @(posedge CLK96) begin
    if (RESET) begin
      state_reg   <= ST_IDLE;
      win_cnt_reg <= '0;
      acc_reg     <= '0;
      run_reg     <= 1'b0;
      COUNT       <= '0;
      MIN_GAP     <= GAP_SAT;
      MAX_GAP     <= '0;
      VALID       <= 1'b0;
      LOCKED      <= 1'b0;
      ERR         <= 1'b0;
    end else begin
      VALID <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          win_cnt_reg <= '0;
          acc_reg     <= '0;
          run_reg     <= 1'b0;
          LOCKED      <= 1'b0;
          if (EN) state_reg <= ST_SETTLE;
        end
        ST_SETTLE, ST_MEASURE: begin
          if (!EN) begin
            // Partial window is thrown away.
            state_reg   <= ST_IDLE;
            win_cnt_reg <= '0;
            acc_reg     <= '0;
            run_reg     <= 1'b0;
            LOCKED      <= 1'b0;
          end else if (win_end) begin
            win_cnt_reg <= '0;
            acc_reg     <= '0;
            state_reg   <= ST_MEASURE;
            if (state_reg == ST_MEASURE) begin
              COUNT   <= count_next;
              MIN_GAP <= trk_min;
              MAX_GAP <= trk_max;
              VALID   <= 1'b1;
              if (in_tol) begin
                // Lock on the second consecutive good window.
                run_reg <= 1'b1;
                LOCKED  <= run_reg;
              end else begin
                run_reg <= 1'b0;
                LOCKED  <= 1'b0;
                ERR     <= 1'b1;
              end
            end
          end else begin
            win_cnt_reg <= win_cnt_reg + WCW'(1);
            acc_reg     <= count_next;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cen_rate_monitor.sv
// Directed bench for cen_rate_monitor with a window-level scoreboard.
module tb_cen_rate_monitor;

  localparam int WIN = 64;
  localparam int EXP = 16;
  localparam int TOLV = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        cen = 1'b0;
  logic [23:0] count;
  logic [7:0]  min_gap;
  logic [7:0]  max_gap;
  logic        valid;
  logic        locked;
  logic        err;

  always #5 clk = ~clk;

  cen_rate_monitor #(.WINDOW(WIN), .EXPECT(EXP), .TOL(TOLV), .CW(24)) dut (
    .CLK96   (clk),
    .RESET   (rst),
    .EN      (en),
    .CEN     (cen),
    .COUNT   (count),
    .MIN_GAP (min_gap),
    .MAX_GAP (max_gap),
    .VALID   (valid),
    .LOCKED  (locked),
    .ERR     (err)
  );

  typedef struct {
    int count;
    int mn;
    int mx;
    int locked;
    int err;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int first_valid_cyc = -1;
  int nvalid = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  // Scoreboard consumer: every VALID strobe pops one expected window.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      exp_t e;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      nvalid++;
      check("valid_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        $display("[TB] window %0d: count=%0d min=%0d max=%0d locked=%0d err=%0d",
                 nvalid, count, min_gap, max_gap, locked, err);
        check("count",  32'(count),   32'(e.count));
        check("min_gap", 32'(min_gap), 32'(e.mn));
        check("max_gap", 32'(max_gap), 32'(e.mx));
        check("locked", 32'(locked),  32'(e.locked));
        check("err",    32'(err),     32'(e.err));
      end
    end
  end

  // Stimulus pattern and reference model state.
  typedef enum int {M_NONE, M_4, M_1, M_ALT} mode_t;
  mode_t mode = M_4;
  int  g = 0;
  int  next_pulse = 3;
  int  last = -1;
  bit  alt_flag = 1'b0;
  bit  long_pending = 1'b0;
  int  m_run = 0;
  int  m_locked = 0;
  int  m_err = 0;
  int  m_last_count = 0;

  function automatic int gap_pick();
    if (long_pending) begin
      long_pending = 1'b0;
      return 300;
    end
    case (mode)
      M_4: return 4;
      M_1: return 1;
      M_ALT: begin
        alt_flag = ~alt_flag;
        return alt_flag ? 3 : 5;
      end
      default: return 1;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive ncyc cycles of one window starting at its first cycle; a full
  // measured window pushes its expected result.
  task automatic run_window(input bit meas, input int ncyc);
    int wcount = 0;
    int wmin = 255;
    int wmax = 0;
    for (int w = 0; w < ncyc; w++) begin
      bit c = 1'b0;
      if (g == next_pulse) begin
        if (mode != M_NONE) c = 1'b1;
        next_pulse = g + ((mode == M_NONE) ? 1 : gap_pick());
      end
      cen = c;
      if (c) begin
        if (last >= 0) begin
          int gp = g - last;
          if (gp > 255) gp = 255;
          if (gp < wmin) wmin = gp;
          if (gp > wmax) wmax = gp;
        end
        last = g;
        wcount++;
      end
      if (meas && w == WIN - 1) begin
        exp_t e;
        if (wcount >= EXP - TOLV && wcount <= EXP + TOLV) begin
          m_run++;
          m_locked = (m_run >= 2) ? 1 : 0;
        end else begin
          m_run = 0;
          m_locked = 0;
          m_err = 1;
        end
        e.count = wcount;
        e.mn = wmin;
        e.mx = wmax;
        e.locked = m_locked;
        e.err = m_err;
        m_last_count = wcount;
        sb.push_back(e);
      end
      step();
      g++;
    end
  endtask

  task automatic enable_start(input mode_t m);
    mode = m;
    en = 1'b1;
    cen = 1'b0;
    g = 0;
    next_pulse = 3;
    last = -1;
    m_run = 0;
    m_locked = 0;
    step();
    run_window(1'b0, WIN);
  endtask

  initial begin
    int e_cyc;
    // Reset state.
    rst = 1'b1;
    repeat (3) step();
    check("rst_count", 32'(count), 32'd0);
    check("rst_min", 32'(min_gap), 32'd255);
    check("rst_max", 32'(max_gap), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    step();

    // Every 4th cycle, pulse on each terminal cycle; lock on 2nd window.
    e_cyc = cyc;
    enable_start(M_4);
    for (int i = 0; i < 3; i++) run_window(1'b1, WIN);
    check("first_valid_latency", 32'(first_valid_cyc - e_cyc), 32'(2 * WIN + 1));

    // Alternating 3/5 gaps, then one 300-cycle gap.
    mode = M_ALT;
    for (int i = 0; i < 3; i++) run_window(1'b1, WIN);
    long_pending = 1'b1;
    for (int i = 0; i < 7; i++) run_window(1'b1, WIN);

    // CEN every cycle, then absent.
    mode = M_1;
    for (int i = 0; i < 2; i++) run_window(1'b1, WIN);
    mode = M_NONE;
    for (int i = 0; i < 2; i++) run_window(1'b1, WIN);

    // Relock, then drop EN mid-window.
    mode = M_4;
    for (int i = 0; i < 3; i++) run_window(1'b1, WIN);
    check("locked_before_drop", 32'(locked), 32'd1);
    run_window(1'b1, 20);
    en = 1'b0;
    cen = 1'b0;
    step();
    check("drop_locked", 32'(locked), 32'd0);
    check("drop_valid", 32'(valid), 32'd0);
    repeat (10) step();
    check("idle_hold_count", 32'(count), 32'(m_last_count));
    check("idle_err_sticky", 32'(err), 32'd1);

    // Re-enable, relock, then RESET mid-MEASURE.
    enable_start(M_4);
    for (int i = 0; i < 2; i++) run_window(1'b1, WIN);
    run_window(1'b1, 30);
    rst = 1'b1;
    en = 1'b0;
    cen = 1'b0;
    step();
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_min", 32'(min_gap), 32'd255);
    check("mid_rst_max", 32'(max_gap), 32'd0);
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_locked", 32'(locked), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    repeat (5) step();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cen_rate_monitor.md
# cen_rate_monitor

Measures a clock-enable pulse train in the CLK96 domain and reports its pulse count per fixed window, minimum and maximum inter-pulse gap, and a lock flag against an expected rate. It sits downstream of the core's fractional clock-enable generators (video 13.5/6.75 MHz, audio 3.375/1.6875 MHz, OKI 2.7 MHz) as their consumer-side checker, for simulation benches and an optional debug overlay.

## Interface
- WINDOW, 96000: CLK96 cycles per measurement window (1 ms); ≥ 2.
- EXPECT, 13500: expected CEN pulses per window.
- TOL, 2: allowed |count − EXPECT| for an in-tolerance window.
- CW, 24: width of the count output; must hold WINDOW.
- CLK96  in  1  96 MHz clock; the only clock.
- RESET  in  1  synchronous, active-high reset.
- EN  in  1  measurement enable; level.
- CEN  in  1  clock-enable pulse train under test.
- COUNT  out  CW  pulse count of the last completed window.
- MIN_GAP  out  8  smallest gap in CLK96 cycles in the last window; saturating.
- MAX_GAP  out  8  largest gap in the last window; saturating.
- VALID  out  1  one-cycle strobe: COUNT/MIN_GAP/MAX_GAP updated.
- LOCKED  out  1  rate lock flag.
- ERR  out  1  sticky: any out-of-tolerance window since RESET.

## Operation
- States: IDLE, SETTLE, MEASURE.
- IDLE: entered on RESET or EN=0; window counter, pulse accumulator and gap counter held at 0; LOCKED cleared; published outputs hold their values. EN=1 → SETTLE.
- SETTLE: runs one full window; gap and count tracked but discarded (no VALID, no lock update). At window end → MEASURE.
- MEASURE: continuous back-to-back windows. At each window end, publish and evaluate, then start the next window with no idle cycle.
- Window counter counts 0..WINDOW−1; the terminal cycle is the one at WINDOW−1, and a CEN in that cycle belongs to the ending window.
- Gap: cycles from one CEN to the next; consecutive-cycle CENs give gap 1. Gap counter runs across window boundaries; a gap is attributed to the window containing its closing pulse. The first pulse after entering SETTLE closes no gap.
- Gap counter saturates at 255; MIN/MAX trackers reset to 255/0 at window start. A window with no closed gap publishes MIN_GAP=255, MAX_GAP=0.
- Pulse accumulator saturates at 2^CW−1.
- In-tolerance: EXPECT−TOL ≤ COUNT ≤ EXPECT+TOL, evaluated with CW+1-bit signed arithmetic (no underflow when TOL > EXPECT).
- LOCKED: set after 2 consecutive in-tolerance windows; cleared by a single out-of-tolerance window. ERR is set by any out-of-tolerance window and cleared only by RESET.
- EN dropping mid-window: the partial window is discarded, IDLE is entered next cycle, and LOCKED clears.

## Timing
- Reset values: COUNT=0, MIN_GAP=255, MAX_GAP=0, VALID=0, LOCKED=0, ERR=0, state IDLE.
- Window boundary: the terminal cycle is T. COUNT/MIN/MAX registered at T+1, with VALID high at T+1 only. LOCKED/ERR update at T+1.
- First VALID after EN rises at cycle E: E+1 (IDLE→SETTLE) + WINDOW (settle) + WINDOW → strobe at E+2·WINDOW+1.
- CEN may be high every cycle; count then equals WINDOW, with gaps of 1.
- RESET has priority over everything and applies in the same cycle.

## Structure
- Shared package cen_mon_pkg: state enum, gap width (8), saturation constant 255, and the CEN_RATES constant set (13500, 6750, 3375, 1688, 2700 pulses/ms).
- One natural sub-module, cen_gap_tracker: the gap counter plus min/max with saturation, with ports clk/rst/cen/win_start and min/max outputs.

## Test plan
- WINDOW=64, EXPECT=16, TOL=0, CEN every 4th cycle, EN=1 → first VALID at 129 cycles after EN, COUNT=16, MIN=MAX=4, LOCKED after 2nd VALID, ERR=0.
- Same setup, CEN every cycle → COUNT=64, MIN=MAX=1, LOCKED=0, ERR=1 after the first VALID.
- CEN absent (held 0) → COUNT=0, MIN_GAP=255, MAX_GAP=0, ERR=1.
- Alternating gaps 3/5 (EXPECT=16, TOL=1) → COUNT 16±1, MIN=3, MAX=5, LOCKED=1; then one gap of 300 → MAX_GAP=255, that window fails, LOCKED drops, ERR=1.
- CEN on the terminal cycle T → counted in the ending window (COUNT includes it); next window's first gap measured from T.
- EN low mid-window, or RESET asserted mid-MEASURE → no VALID for the partial window, LOCKED=0 next cycle; RESET also restores every output to its reset value.
